pixel_write_coalescer: RTL and testbench
========================================

Name: pixel_write_coalescer

Overview:
- Sits directly downstream of the rectangle generator, between its arbiter-side output (32-bit data, 16-bit word address, 4-bit wben, rts/rtr) and the frame-memory arbiter write port.
- The generator emits one byte-lane write per colour component, so consecutive writes often target the same word. This block merges them into a single hold register and emits full or aged words through a small FIFO.
- Goal: reduce arbiter write traffic and decouple generator stalls from arbiter back-pressure.

Parameters:
- ADDR_W, 16, word address width.
- DEPTH, 4, output FIFO entries; must be a power of 2, minimum 2.
- TIMEOUT, 15, idle cycles before a partial hold word is forced out; minimum 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_data  in  32  write data from the generator; byte i is lane i.
- in_addr  in  ADDR_W  word address from the generator.
- in_wben  in  4  byte-lane enables from the generator.
- in_rts  in  1  generator has a write.
- in_rtr  out  1  block can accept a write.
- flush  in  1  level; forces the hold word out.
- mem_data  out  32  head-of-FIFO data.
- mem_addr  out  ADDR_W  head-of-FIFO address.
- mem_wben  out  4  head-of-FIFO lane enables.
- mem_rts  out  1  FIFO not empty.
- mem_rtr  in  1  arbiter accepts.
- idle  out  1  hold empty and FIFO empty.

Behaviour:
- Reset (rst high at a clock edge): hold_valid=0, FIFO count=0, rd/wr pointers=0, idle_cnt=0. Outputs: mem_rts=0, idle=1, mem_* data/addr/wben=0. in_rtr=0 while rst is high. A reset mid-operation discards the hold word and all FIFO contents without emitting them.
- Transfers: in_xfc = in_rts & in_rtr; mem_xfc = mem_rts & mem_rtr.
- hit = hold_valid & (in_addr == hold_addr). full = (count == DEPTH).
- in_rtr = !rst & (!hold_valid | hit | !full).
  - Uses only registered count and hold state; no combinational path from mem_rtr to in_rtr.
- On in_xfc with in_wben == 0: write is accepted and dropped; no state change, idle_cnt not cleared.
- On in_xfc, hit: for each lane i with in_wben[i]=1, hold_data byte i <= in_data byte i; hold_wben <= hold_wben | in_wben; idle_cnt <= 0.
- On in_xfc, miss with hold_valid: push {hold_addr, hold_data, hold_wben} to the FIFO, then load hold from the input. Input bytes in disabled lanes are zeroed. idle_cnt <= 0.
- On in_xfc with hold empty: load hold as above; hold_valid <= 1.
- Eviction without input: when there is no in_xfc this cycle, hold_valid=1, !full, and any of:
  - hold_wben == 4'hF
  - idle_cnt == TIMEOUT
  - flush = 1
  then push the hold word and set hold_valid <= 0.
- Priority: an input transfer always beats eviction in the same cycle. A hit merge arriving on a timeout cycle merges, and the counter restarts.
- idle_cnt: increments while hold_valid and no in_xfc, saturating at TIMEOUT; cleared on eviction.
- FIFO: show-ahead; mem_* always reflect the head entry.
  - Push and pop in the same cycle are allowed at any count, including full.
  - count width is log2(DEPTH)+1; pointers wrap modulo DEPTH.
- Latency:
  - Full-word path: write fills wben=F at edge k; hold is evicted at edge k+1; mem_rts=1 from k+1.
  - Single partial write followed by no input: mem_rts rises TIMEOUT+1 edges after acceptance.
- idle = !hold_valid & (count == 0).
- Ordering: words leave in acceptance order. Addresses are never reordered, and a non-adjacent revisit of the same address produces a second write.

Optional Feature:
- Macro: PIXEL_WRITE_COALESCER_STATS_EN.
- When defined: adds output port merge_cnt[15:0], reset to 0. It increments by 1 on every hit in_xfc with nonzero in_wben and saturates at 16'hFFFF. It also adds input stats_clr, which synchronously zeroes merge_cnt and has priority over increment.
- When undefined: neither port exists and there is no counter logic; all other behaviour is identical.

Test Plan:
- Merge to full word: four writes to addr 16'h0010 with wben 1,2,4,8 and data bytes 8'h11,8'h22,8'h33,8'h44 in their lanes, mem_rtr=1.
  -> exactly one mem_xfc: addr 16'h0010, wben 4'hF, data 32'h44332211, mem_rts rising one edge after the 4th accept.
- Address change: wben 1 to 16'h0010, then wben 2 to 16'h0011.
  -> first word (0x0010, wben 1) is pushed on the second accept; second word appears after TIMEOUT=15 idle cycles, never earlier.
- Back-pressure: mem_rtr=0, DEPTH=4, five distinct-address full-word writes.
  -> in_rtr drops with 4 FIFO entries plus hold occupied; a sixth distinct write stalls. Raising mem_rtr drains in order with no loss or duplication.
- Flush: one wben-2 write, then flush pulsed 3 cycles later.
  -> word pushed on the flush edge; idle returns to 1 after mem_xfc.
- Reset mid-stream: assert rst with 3 FIFO entries and a valid hold.
  -> next cycle mem_rts=0, idle=1, in_rtr=0 during reset. No stale word is emitted after release.
- Stats (macro on): the first scenario.
  -> merge_cnt=3. stats_clr asserted with a simultaneous hit -> merge_cnt=0.

Source files
------------

// File: rtl/pixel_write_coalescer.sv
// pixel_write_coalescer
// Merges byte-lane writes from the rectangle generator into a single hold
// word and forwards full, aged or flushed words to the frame-memory arbiter
// through a small show-ahead FIFO.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_data/addr/wben     generator write (byte i of data is lane i)
//   in_rts / in_rtr       generator handshake
//   flush                 level; forces the hold word out
//   mem_data/addr/wben    head-of-FIFO word
//   mem_rts / mem_rtr     arbiter handshake
//   idle                  hold empty and FIFO empty
//
// Optional feature (macro PIXEL_WRITE_COALESCER_STATS_EN):
//   merge_cnt[15:0]       saturating count of merged (hit) writes
//   stats_clr             synchronous clear of merge_cnt, beats increment
module pixel_write_coalescer #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [3:0]        in_wben,
  input  logic              in_rts,
  output logic              in_rtr,
  input  logic              flush,
  output logic [31:0]       mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wben,
  output logic              mem_rts,
  input  logic              mem_rtr,
`ifdef PIXEL_WRITE_COALESCER_STATS_EN
  output logic [15:0]       merge_cnt,
  input  logic              stats_clr,
`endif
  output logic              idle
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        wben;
  } word_t;

  // Hold register and its age counter
  logic              hold_valid_q, hold_valid_d;
  logic [ADDR_W-1:0] hold_addr_q,  hold_addr_d;
  logic [31:0]       hold_data_q,  hold_data_d;
  logic [3:0]        hold_wben_q,  hold_wben_d;
  logic [IDLE_W-1:0] idle_cnt_q,   idle_cnt_d;

  // Output FIFO
  word_t             fifo_q [DEPTH];
  word_t             fifo_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;

  logic        hit_c;
  logic        full_c;
  logic        in_xfc_c;
  logic        wr_en_c;
  logic        mem_xfc_c;
  logic        evict_c;
  logic        push_c;
  logic [31:0] in_mask_c;
  word_t       push_word_c;

  // Handshake and transfer qualifiers; in_rtr depends only on registered state
  always_comb begin
    hit_c     = hold_valid_q && (in_addr == hold_addr_q);
    full_c    = (count_q == CNT_W'(DEPTH));
    in_rtr    = !rst && (!hold_valid_q || hit_c || !full_c);
    in_xfc_c  = in_rts && in_rtr;
    wr_en_c   = in_xfc_c && (in_wben != 4'h0);
    mem_rts   = (count_q != CNT_W'(0));
    mem_xfc_c = mem_rts && mem_rtr;
    in_mask_c = {{8{in_wben[3]}}, {8{in_wben[2]}}, {8{in_wben[1]}}, {8{in_wben[0]}}};
    // A zero-enable transfer still counts as an input transfer and blocks eviction
    evict_c   = !in_xfc_c && hold_valid_q && !full_c &&
                ((hold_wben_q == 4'hF) || (idle_cnt_q == IDLE_W'(TIMEOUT)) || flush);
    push_c    = evict_c || (wr_en_c && hold_valid_q && !hit_c);
    push_word_c = '{addr: hold_addr_q, data: hold_data_q, wben: hold_wben_q};
  end

  // Hold register next state: input beats eviction, eviction beats aging
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    hold_wben_d  = hold_wben_q;
    idle_cnt_d   = idle_cnt_q;
    if (wr_en_c) begin
      if (hit_c) begin
        hold_data_d = (hold_data_q & ~in_mask_c) | (in_data & in_mask_c);
        hold_wben_d = hold_wben_q | in_wben;
      end else begin
        hold_addr_d = in_addr;
        hold_data_d = in_data & in_mask_c;
        hold_wben_d = in_wben;
      end
      hold_valid_d = 1'b1;
      idle_cnt_d   = '0;
    end else if (evict_c) begin
      hold_valid_d = 1'b0;
      idle_cnt_d   = '0;
    end else if (hold_valid_q && !in_xfc_c && (idle_cnt_q != IDLE_W'(TIMEOUT))) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end
  end

  // FIFO next state; push and pop may coincide at any occupancy
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_c) begin
      fifo_d[wr_ptr_q] = push_word_c;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (mem_xfc_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(mem_xfc_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      hold_wben_q  <= '0;
      idle_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      hold_wben_q  <= hold_wben_d;
      idle_cnt_q   <= idle_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fifo_q       <= fifo_d;
    end
  end

  // Show-ahead head and status outputs
  always_comb begin
    mem_addr = fifo_q[rd_ptr_q].addr;
    mem_data = fifo_q[rd_ptr_q].data;
    mem_wben = fifo_q[rd_ptr_q].wben;
    idle     = !hold_valid_q && (count_q == CNT_W'(0));
  end

`ifdef PIXEL_WRITE_COALESCER_STATS_EN
  logic [15:0] merge_cnt_q, merge_cnt_d;

  // Saturating merge counter; clear beats increment
  always_comb begin
    merge_cnt_d = merge_cnt_q;
    if (stats_clr) begin
      merge_cnt_d = '0;
    end else if (wr_en_c && hit_c && (merge_cnt_q != 16'hFFFF)) begin
      merge_cnt_d = merge_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      merge_cnt_q <= '0;
    end else begin
      merge_cnt_q <= merge_cnt_d;
    end
  end

  assign merge_cnt = merge_cnt_q;
`endif

endmodule

// File: tb/tb_pixel_write_coalescer.sv
// Self-checking bench for pixel_write_coalescer: directed scenarios plus
// randomized traffic, compared every cycle against a queue-based model.
module tb_pixel_write_coalescer;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       in_data = '0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [3:0]        in_wben = '0;
  logic              in_rts = 1'b0;
  logic              in_rtr;
  logic              flush = 1'b0;
  logic [31:0]       mem_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wben;
  logic              mem_rts;
  logic              mem_rtr = 1'b0;
  logic              idle;
`ifdef PIXEL_WRITE_COALESCER_STATS_EN
  logic [15:0]       merge_cnt;
  logic              stats_clr = 1'b0;
`endif

  pixel_write_coalescer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_addr(in_addr), .in_wben(in_wben),
    .in_rts(in_rts), .in_rtr(in_rtr), .flush(flush),
    .mem_data(mem_data), .mem_addr(mem_addr), .mem_wben(mem_wben),
    .mem_rts(mem_rts), .mem_rtr(mem_rtr),
`ifdef PIXEL_WRITE_COALESCER_STATS_EN
    .merge_cnt(merge_cnt), .stats_clr(stats_clr),
`endif
    .idle(idle)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: hold word plus a queue standing in for the FIFO
  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  w;
  } wd_t;

  wd_t         m_q[$];
  bit          m_hv = 1'b0;
  logic [15:0] m_addr = '0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_wben = '0;
  int          m_cnt = 0;
  int          m_mc = 0;
  int          dut_xfc = 0;
  logic [15:0] dut_pops[$];

  always @(posedge clk) begin : model
    int  sz;
    bit  hit, rtr, ixfc;
    if (!rst && mem_rts && mem_rtr) begin
      dut_xfc++;
      dut_pops.push_back(mem_addr);
    end
    sz = m_q.size();
    if (rst) begin
      m_hv = 1'b0; m_addr = '0; m_data = '0; m_wben = '0; m_cnt = 0; m_mc = 0;
      m_q.delete();
    end else begin
      hit  = m_hv && (in_addr == m_addr);
      rtr  = !m_hv || hit || (sz < int'(DEPTH));
      ixfc = in_rts && rtr;
      if (sz > 0 && mem_rtr) void'(m_q.pop_front());
`ifdef PIXEL_WRITE_COALESCER_STATS_EN
      if (stats_clr) m_mc = 0;
      else if (ixfc && hit && in_wben != 4'h0 && m_mc < 65535) m_mc++;
`endif
      if (ixfc && in_wben != 4'h0) begin
        if (hit) begin
          for (int i = 0; i < 4; i++)
            if (in_wben[i]) m_data[8*i +: 8] = in_data[8*i +: 8];
          m_wben = m_wben | in_wben;
        end else begin
          if (m_hv) m_q.push_back('{a: m_addr, d: m_data, w: m_wben});
          m_addr = in_addr;
          m_data = '0;
          for (int i = 0; i < 4; i++)
            if (in_wben[i]) m_data[8*i +: 8] = in_data[8*i +: 8];
          m_wben = in_wben;
        end
        m_hv  = 1'b1;
        m_cnt = 0;
      end else if (!ixfc && m_hv) begin
        if (sz < int'(DEPTH) && (m_wben == 4'hF || m_cnt == int'(TIMEOUT) || flush)) begin
          m_q.push_back('{a: m_addr, d: m_data, w: m_wben});
          m_hv  = 1'b0;
          m_cnt = 0;
        end else if (m_cnt < int'(TIMEOUT)) begin
          m_cnt++;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin : cmp
    bit exp_rtr;
    if (chk_en) begin
      exp_rtr = !rst && (!m_hv || (in_addr == m_addr) || (m_q.size() < int'(DEPTH)));
      check("in_rtr", 64'(in_rtr), 64'(exp_rtr));
      check("mem_rts", 64'(mem_rts), 64'(m_q.size() != 0));
      check("idle", 64'(idle), 64'(!m_hv && m_q.size() == 0));
      if (m_q.size() != 0)
        check("head", 64'({mem_addr, mem_data, mem_wben}), 64'({m_q[0].a, m_q[0].d, m_q[0].w}));
`ifdef PIXEL_WRITE_COALESCER_STATS_EN
      check("merge_cnt", 64'(merge_cnt), 64'(m_mc));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one write and hold it until accepted (bounded)
  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] w);
    bit acc;
    int guard;
    in_addr = a; in_data = d; in_wben = w; in_rts = 1'b1;
    acc = 1'b0;
    guard = 0;
    while (!acc) begin
      @(negedge clk);
      acc = in_rtr;
      tick();
      guard++;
      if (guard > 200) begin
        check("wr_accept_timeout", 64'(0), 64'(1));
        break;
      end
    end
    in_rts = 1'b0;
  endtask

  initial begin
    int e;
    int base;
    // Reset state
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    @(negedge clk);
    check("rst_in_rtr", 64'(in_rtr), 64'(0));
    check("rst_mem_rts", 64'(mem_rts), 64'(0));
    check("rst_idle", 64'(idle), 64'(1));
    check("rst_mem_bus", 64'({mem_addr, mem_data, mem_wben}), 64'(0));
    tick();
    rst = 1'b0;
    mem_rtr = 1'b1;

    // Merge four byte-lane writes into one full word
    base = dut_xfc;
    wr(16'h0010, 32'h0000_0011, 4'h1);
    wr(16'h0010, 32'h0000_2200, 4'h2);
    wr(16'h0010, 32'h0033_0000, 4'h4);
    wr(16'h0010, 32'h4400_0000, 4'h8);
    @(negedge clk);
    check("merge_early", 64'(mem_rts), 64'(0));
`ifdef PIXEL_WRITE_COALESCER_STATS_EN
    check("stats_merge3", 64'(merge_cnt), 64'(3));
`endif
    tick();
    @(negedge clk);
    check("merge_rts", 64'(mem_rts), 64'(1));
    check("merge_word", 64'({mem_addr, mem_data, mem_wben}), 64'({16'h0010, 32'h4433_2211, 4'hF}));
    repeat (5) tick();
    check("merge_one_xfc", 64'(dut_xfc - base), 64'(1));

`ifdef PIXEL_WRITE_COALESCER_STATS_EN
    // Clear coinciding with a hit: clear wins
    wr(16'h0020, 32'h0000_00AA, 4'h1);
    stats_clr = 1'b1;
    wr(16'h0020, 32'h0000_BB00, 4'h2);
    stats_clr = 1'b0;
    @(negedge clk);
    check("stats_clr_hit", 64'(merge_cnt), 64'(0));
    repeat (20) tick();
`endif

    // Address change pushes the first word; the second ages out
    wr(16'h0010, $urandom, 4'h1);
    wr(16'h0011, $urandom, 4'h2);
    @(negedge clk);
    check("addrchg_first", 64'({mem_rts, mem_addr, mem_wben}), 64'({1'b1, 16'h0010, 4'h1}));
    e = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      @(negedge clk);
      e = i;
      if (mem_rts && mem_addr == 16'h0011) break;
    end
    check("timeout_latency", 64'(e), 64'(TIMEOUT + 1));
    repeat (3) tick();

    // Back-pressure: FIFO full plus hold occupied stalls a new address
    mem_rtr = 1'b0;
    for (int i = 0; i < 5; i++) wr(16'h0100 + 16'(i), $urandom, 4'hF);
    repeat (3) tick();
    in_addr = 16'h0105; in_wben = 4'hF; in_data = $urandom; in_rts = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("bp_stall", 64'(in_rtr), 64'(0));
      tick();
    end
    in_rts = 1'b0;
    dut_pops.delete();
    mem_rtr = 1'b1;
    repeat (20) tick();
    check("bp_drain_count", 64'(dut_pops.size()), 64'(5));
    for (int i = 0; i < 5 && i < dut_pops.size(); i++)
      check("bp_drain_order", 64'(dut_pops[i]), 64'(16'h0100 + 16'(i)));

    // Flush forces a partial word out
    wr(16'h0200, $urandom, 4'h2);
    repeat (3) tick();
    flush = 1'b1;
    @(negedge clk);
    check("flush_before", 64'(mem_rts), 64'(0));
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_push", 64'({mem_rts, mem_addr, mem_wben}), 64'({1'b1, 16'h0200, 4'h2}));
    tick();
    @(negedge clk);
    check("flush_idle", 64'(idle), 64'(1));

    // Reset mid-stream discards FIFO and hold
    mem_rtr = 1'b0;
    wr(16'h0300, $urandom, 4'hF);
    wr(16'h0301, $urandom, 4'hF);
    wr(16'h0302, $urandom, 4'hF);
    tick();
    wr(16'h0303, $urandom, 4'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_rtr", 64'(in_rtr), 64'(0));
    tick();
    @(negedge clk);
    check("rstmid_state", 64'({mem_rts, idle, in_rtr}), 64'({1'b0, 1'b1, 1'b0}));
    tick();
    rst = 1'b0;
    mem_rtr = 1'b1;
    base = dut_xfc;
    repeat (30) tick();
    check("rstmid_no_stale", 64'(dut_xfc - base), 64'(0));

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 299) == 0);
      in_rts  = $urandom_range(0, 1);
      in_addr = 16'h0400 + 16'($urandom_range(0, 3));
      in_data = $urandom;
      in_wben = 4'($urandom_range(0, 15));
      flush   = ($urandom_range(0, 15) == 0);
      mem_rtr = ($urandom_range(0, 9) < 7);
`ifdef PIXEL_WRITE_COALESCER_STATS_EN
      stats_clr = ($urandom_range(0, 49) == 0);
`endif
      tick();
    end
    rst = 1'b0; in_rts = 1'b0; flush = 1'b0; mem_rtr = 1'b1;
`ifdef PIXEL_WRITE_COALESCER_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (40) tick();
    @(negedge clk);
    check("final_idle", 64'(idle), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
